// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: fetches over a shared memory port, decodes the IR into
// datapath strobes and retires exactly one instruction per pass through the FSM.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_IR       = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        isALUreg,
    output logic        isJAL,
    output logic        isJALR,
    output logic        isBranch,
    output logic        isLUI,
    output logic        isAUIPC,
    output logic        isLoad,
    output logic        isStore,
    output logic [3:0]  aluControl,
    output logic        regWrite,
    output logic        pc_we,
    output logic        retire,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_t;

    typedef struct packed {
        logic alureg;
        logic jal;
        logic jalr;
        logic branch;
        logic lui;
        logic auipc;
        logic load;
        logic store;
    } flags_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_cnt;
    flags_t      r_flags;
    logic [3:0]  r_alu;
    logic        r_illegal;
    logic        r_bus_error;

    flags_t      w_dec_flags;
    logic [3:0]  w_dec_alu;
    logic        w_dec_legal;
    logic        w_dec_sys;
    logic [2:0]  w_funct3;
    logic        w_in_access;
    logic        w_timeout;

    assign w_funct3    = r_ir[14:12];
    assign w_in_access = (r_state == StFetch) || (r_state == StMem);
    // A ready arriving in the limit cycle completes the access instead of timing out.
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && !mem_ready
                         && ((r_cnt + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        w_dec_flags = '0;
        w_dec_alu   = 4'b0000;
        w_dec_legal = 1'b1;
        w_dec_sys   = 1'b0;
        case (r_ir[6:0])
            7'b0110111: w_dec_flags.lui   = 1'b1;
            7'b0010111: w_dec_flags.auipc = 1'b1;
            7'b1101111: w_dec_flags.jal   = 1'b1;
            7'b1100111: w_dec_flags.jalr  = 1'b1;
            7'b0000011: w_dec_flags.load  = 1'b1;
            7'b0100011: w_dec_flags.store = 1'b1;
            7'b1100011: begin
                w_dec_flags.branch = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: w_dec_alu = 4'b1000;
                    3'b100, 3'b101: w_dec_alu = 4'b0010;
                    3'b110, 3'b111: w_dec_alu = 4'b0011;
                    default:        w_dec_alu = 4'b0000;
                endcase
            end
            7'b0010011: w_dec_alu = {(w_funct3 == 3'b101) & r_ir[30], w_funct3};
            7'b0110011: begin
                w_dec_flags.alureg = 1'b1;
                w_dec_alu          = {r_ir[30], w_funct3};
            end
            7'b1110011: w_dec_sys   = 1'b1;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        pc_we    = 1'b0;
        retire   = 1'b0;
        regWrite = 1'b0;
        halted   = 1'b0;
        case (r_state)
            StIdle: w_next = StFetch;
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready)      w_next = StDecode;
                else if (w_timeout) w_next = StHalt;
            end
            StDecode: begin
                if (w_dec_sys || !w_dec_legal) w_next = StHalt;
                else                           w_next = StExec;
            end
            StExec: w_next = (r_flags.load || r_flags.store) ? StMem : StWb;
            StMem: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = r_flags.store;
                if (mem_ready)      w_next = StWb;
                else if (w_timeout) w_next = StHalt;
            end
            StWb: begin
                pc_we    = 1'b1;
                retire   = 1'b1;
                regWrite = !(r_flags.branch || r_flags.store);
                w_next   = StFetch;
            end
            StHalt:  halted = 1'b1;
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ir        <= RESET_IR;
            r_mdr       <= 32'd0;
            r_cnt       <= 32'd0;
            r_flags     <= '0;
            r_alu       <= 4'b0000;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == StFetch && mem_ready) r_ir <= mem_rdata;
            if (r_state == StMem && mem_ready && r_flags.load) r_mdr <= mem_rdata;

            if (w_next != r_state && (w_next == StFetch || w_next == StMem)) begin
                r_cnt <= 32'd0;
            end else if (w_in_access && !mem_ready) begin
                r_cnt <= r_cnt + 32'd1;
            end

            // Flags live only from EXEC through WB; anything heading to FETCH/HALT drops them.
            if (r_state == StDecode && w_next == StExec) begin
                r_flags <= w_dec_flags;
                r_alu   <= w_dec_alu;
            end else if (w_next == StFetch || w_next == StHalt) begin
                r_flags <= '0;
                r_alu   <= 4'b0000;
            end

            if (r_state == StDecode && !w_dec_legal) r_illegal <= 1'b1;
            if (w_in_access && w_next == StHalt) r_bus_error <= 1'b1;
        end
    end

    assign instr      = r_ir;
    assign mdr        = r_mdr;
    assign isALUreg   = r_flags.alureg;
    assign isJAL      = r_flags.jal;
    assign isJALR     = r_flags.jalr;
    assign isBranch   = r_flags.branch;
    assign isLUI      = r_flags.lui;
    assign isAUIPC    = r_flags.auipc;
    assign isLoad     = r_flags.load;
    assign isStore    = r_flags.store;
    assign aluControl = r_alu;
    assign illegal    = r_illegal;
    assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction's cycle-by-cycle strobes are
// predicted from an instruction-level model (phase sequence, wait counts, decode table).
module tb_multicycle_controller;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    localparam int PH_IDLE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_EXEC   = 3;
    localparam int PH_MEM    = 4;
    localparam int PH_WB     = 5;
    localparam int PH_HALT   = 6;

    typedef struct packed {
        logic       alureg, jal, jalr, br, lui, auipc, ld, st;
        logic [3:0] alu;
        logic       legal, sys;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_req, mem_we, addr_sel;
    logic [31:0] instr, mdr;
    logic        isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore;
    logic [3:0]  aluControl;
    logic        regWrite, pc_we, retire, halted, illegal, bus_error;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_mdr = 32'd0;
    logic [20:0] w_obs;

    multicycle_controller #(
        .TIMEOUT_CYCLES(TO),
        .RESET_IR      (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .instr     (instr),
        .mdr       (mdr),
        .isALUreg  (isALUreg),
        .isJAL     (isJAL),
        .isJALR    (isJALR),
        .isBranch  (isBranch),
        .isLUI     (isLUI),
        .isAUIPC   (isAUIPC),
        .isLoad    (isLoad),
        .isStore   (isStore),
        .aluControl(aluControl),
        .regWrite  (regWrite),
        .pc_we     (pc_we),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    assign w_obs = {mem_req, mem_we, addr_sel, pc_we, retire, regWrite, halted, illegal,
                    bus_error, isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad,
                    isStore, aluControl};

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t       d;
        logic [2:0] f3;
        f3      = w[14:12];
        d       = '0;
        d.legal = 1'b1;
        case (w[6:0])
            7'b0110111: d.lui   = 1'b1;
            7'b0010111: d.auipc = 1'b1;
            7'b1101111: d.jal   = 1'b1;
            7'b1100111: d.jalr  = 1'b1;
            7'b0000011: d.ld    = 1'b1;
            7'b0100011: d.st    = 1'b1;
            7'b1100011: begin
                d.br = 1'b1;
                if (f3 < 3'd2)      d.alu = 4'b1000;
                else if (f3 < 3'd6) d.alu = 4'b0010;
                else                d.alu = 4'b0011;
            end
            7'b0010011: d.alu = {(f3 == 3'd5) && w[30], f3};
            7'b0110011: begin
                d.alureg = 1'b1;
                d.alu    = {w[30], f3};
            end
            7'b1110011: d.sys   = 1'b1;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [20:0] exp_vec(input int ph, input dec_t d, input logic ill,
                                            input logic be);
        logic       act;
        logic [7:0] fl;
        logic [3:0] alu;
        act = (ph == PH_EXEC) || (ph == PH_MEM) || (ph == PH_WB);
        fl  = act ? {d.alureg, d.jal, d.jalr, d.br, d.lui, d.auipc, d.ld, d.st} : 8'd0;
        alu = act ? d.alu : 4'd0;
        return {(ph == PH_FETCH) || (ph == PH_MEM), (ph == PH_MEM) && d.st, ph == PH_MEM,
                ph == PH_WB, ph == PH_WB, (ph == PH_WB) && !(d.br || d.st), ph == PH_HALT,
                (ph == PH_HALT) && ill, (ph == PH_HALT) && be, fl, alu};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 8);
        case (k)
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;
            4: begin
                w[6:0]   = 7'b1100011;
                f3       = 3'($urandom_range(0, 5));
                w[14:12] = (f3 < 3'd2) ? f3 : f3 + 3'd2;
            end
            5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;
            7: w[6:0] = 7'b0010011;
            default: w[6:0] = 7'b0110011;
        endcase
        return w;
    endfunction

    // fwait/mwait = wait cycles before ready; a value >= TO means ready never comes in time.
    task automatic exec_instr(input string name, input logic [31:0] word, input int fwait,
                              input int mwait, input logic [31:0] ld_data);
        dec_t        d;
        logic [20:0] e;
        logic        stop, h_ill, h_be;
        d     = model_decode(word);
        stop  = 1'b0;
        h_ill = 1'b0;
        h_be  = 1'b0;
        for (int c = 0; c <= fwait && c < int'(TO); c++) begin
            mem_ready = (c == fwait);
            mem_rdata = (c == fwait) ? word : $urandom;
            @(negedge clk);
            e = exp_vec(PH_FETCH, d, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL %s fetch%0d: got %h want %h", name, c, w_obs, e);
            end
            @(posedge clk); #1;
        end
        if (fwait >= int'(TO)) begin
            stop = 1'b1;
            h_be = 1'b1;
        end
        if (!stop) begin
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            @(negedge clk);
            e = exp_vec(PH_DECODE, d, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== e || instr !== word) begin
                n_err++;
                $display("FAIL %s decode: got %h/%h want %h/%h", name, w_obs, instr, e, word);
            end
            @(posedge clk); #1;
            if (!d.legal || d.sys) begin
                stop  = 1'b1;
                h_ill = !d.legal;
            end
        end
        if (!stop) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            e = exp_vec(PH_EXEC, d, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL %s exec: got %h want %h", name, w_obs, e);
            end
            @(posedge clk); #1;
        end
        if (!stop && (d.ld || d.st)) begin
            for (int c = 0; c <= mwait && c < int'(TO); c++) begin
                mem_ready = (c == mwait);
                mem_rdata = (c == mwait) ? ld_data : $urandom;
                @(negedge clk);
                e = exp_vec(PH_MEM, d, 1'b0, 1'b0);
                n_vec++;
                if (w_obs !== e) begin
                    n_err++;
                    $display("FAIL %s mem%0d: got %h want %h", name, c, w_obs, e);
                end
                @(posedge clk); #1;
                if (c == mwait && d.ld) exp_mdr = ld_data;
            end
            if (mwait >= int'(TO)) begin
                stop = 1'b1;
                h_be = 1'b1;
            end
        end
        if (!stop) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            e = exp_vec(PH_WB, d, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== e || mdr !== exp_mdr) begin
                n_err++;
                $display("FAIL %s wb: got %h/%h want %h/%h", name, w_obs, mdr, e, exp_mdr);
            end
            @(posedge clk); #1;
        end else begin
            repeat (3) begin
                mem_ready = 1'($urandom);
                @(negedge clk);
                e = exp_vec(PH_HALT, d, h_ill, h_be);
                n_vec++;
                if (w_obs !== e) begin
                    n_err++;
                    $display("FAIL %s halt: got %h want %h", name, w_obs, e);
                end
                @(posedge clk); #1;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_mdr = 32'd0;
        n_vec++;
        if (w_obs !== 21'd0 || instr !== NOP || mdr !== 32'd0) begin
            n_err++;
            $display("FAIL reset: got %h/%h/%h want 0/%h/0", w_obs, instr, mdr, NOP);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (w_obs !== 21'd0 || instr !== NOP) begin
            n_err++;
            $display("FAIL idle: got %h/%h want 0/%h", w_obs, instr, NOP);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        exec_instr("addi", 32'h00500093, 0, 0, 32'd0);
        exec_instr("sub",  32'h40208233, 1, 0, 32'd0);
        exec_instr("srai", 32'h4020d193, 2, 0, 32'd0);
    endtask

    task automatic test_load_store();
        exec_instr("lw",  32'h0000a103, 0, 3, $urandom);
        exec_instr("sw",  32'h0020a023, 1, 2, $urandom);
        exec_instr("beq", 32'h00208463, 0, 0, 32'd0);
        exec_instr("lw_limit", 32'h0000a103, 3, int'(TO) - 1, $urandom);
    endtask

    task automatic test_halt();
        test_reset();
        release_reset();
        exec_instr("illegal", 32'hFFFFFFFF, 0, 0, 32'd0);
        test_reset();
        release_reset();
        exec_instr("ecall", 32'h00000073, 1, 0, 32'd0);
    endtask

    task automatic test_timeout();
        test_reset();
        release_reset();
        exec_instr("fetch_to", 32'h00500093, int'(TO), 0, 32'd0);
        test_reset();
        release_reset();
        exec_instr("mem_to", 32'h0000a103, 0, int'(TO) + 5, 32'd0);
    endtask

    task automatic test_reset_mid_mem();
        logic [20:0] e;
        test_reset();
        release_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000a103;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        e = exp_vec(PH_MEM, model_decode(32'h0000a103), 1'b0, 1'b0);
        n_vec++;
        if (w_obs !== e) begin
            n_err++;
            $display("FAIL pre_reset_mem: got %h want %h", w_obs, e);
        end
        reset = 1'b1;
        #1;
        exp_mdr = 32'd0;
        n_vec++;
        if (w_obs !== 21'd0 || instr !== NOP || mdr !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset: got %h/%h/%h want 0/%h/0", w_obs, instr, mdr, NOP);
        end
        release_reset();
        exec_instr("after_reset", 32'h00500093, 0, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        test_reset();
        release_reset();
        for (int i = 0; i < 40; i++) begin
            exec_instr("rand", rand_instr(), $urandom_range(0, TO - 1),
                       $urandom_range(0, TO - 1), $urandom);
        end
    endtask

    initial begin
        test_reset();
        release_reset();
        test_alu();
        test_load_store();
        test_halt();
        test_timeout();
        test_reset_mid_mem();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
